// File: rtl/ex_stage.sv
// Execute stage of the five-stage RV32IM pipeline: ALU, single-cycle multiply, branch/jump
// resolution, and an iterative radix-2 divider that stalls upstream while it runs.
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ID_Valid,
  input  logic [XLEN-1:0] ID_Pc,
  input  logic [XLEN-1:0] ID_Pc4,
  input  logic [XLEN-1:0] ID_Rs1data,
  input  logic [XLEN-1:0] ID_Rs2data,
  input  logic [XLEN-1:0] ID_Imm,
  input  logic [4:0]      ID_RegD,
  input  logic [4:0]      ID_AluOp,
  input  logic            ID_ASel,
  input  logic            ID_BSel,
  input  logic            ID_Branch,
  input  logic [2:0]      ID_BrFunct3,
  input  logic [1:0]      ID_Jump,
  input  logic            ID_WReg,
  input  logic            ID_Wmem,
  input  logic            ID_Rmem,
  input  logic [1:0]      ID_WBsel,
  output logic            EX_Stall,
  output logic            EX_Redirect,
  output logic [XLEN-1:0] EX_Target,
  output logic [XLEN-1:0] EX_Pc4,
  output logic [XLEN-1:0] EX_Alu_Result,
  output logic [XLEN-1:0] EX_Wdata,
  output logic [XLEN-1:0] EX_Imm,
  output logic [4:0]      EX_RegD,
  output logic            EX_WReg,
  output logic            EX_Wmem,
  output logic            EX_Rmem,
  output logic [1:0]      EX_WBsel
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  logic [XLEN-1:0]   op_a, op_b, alu_res, fast_res, div_res, a_abs, b_abs, q_fix, r_fix;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
  logic              is_div, div_signed, is_rem, div_by_zero, div_ovf, div_start;
  logic              a_neg, b_neg, br_taken, load;
  logic [XLEN:0]     step_tmp, step_diff;

  div_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic              negq_q, negq_d, negr_q, negr_d;

  logic            redirect_q, redirect_d, wreg_q, wreg_d, wmem_q, wmem_d, rmem_q, rmem_d;
  logic [XLEN-1:0] target_q, target_d, pc4_q, pc4_d, res_q, res_d;
  logic [XLEN-1:0] wdata_q, wdata_d, imm_q, imm_d;
  logic [4:0]      regd_q, regd_d;
  logic [1:0]      wbsel_q, wbsel_d;

  assign op_a = ID_ASel ? ID_Pc : ID_Rs1data;
  assign op_b = ID_BSel ? ID_Imm : ID_Rs2data;

  // One product serves all four multiplies; the extension bits pick the signedness.
  assign mul_a = {{XLEN{op_a[XLEN-1] & (ID_AluOp == 5'd12 || ID_AluOp == 5'd13)}}, op_a};
  assign mul_b = {{XLEN{op_b[XLEN-1] & (ID_AluOp == 5'd12)}}, op_b};
  assign mul_p = mul_a * mul_b;

  assign is_div      = ID_AluOp inside {5'd16, 5'd17, 5'd18, 5'd19};
  assign div_signed  = ID_AluOp == 5'd16 || ID_AluOp == 5'd18;
  assign is_rem      = ID_AluOp == 5'd18 || ID_AluOp == 5'd19;
  assign div_by_zero = op_b == '0;
  assign div_ovf     = div_signed && op_a == {1'b1, {XLEN-1{1'b0}}} && op_b == '1;
  assign div_start   = ID_Valid && is_div && !div_by_zero && !div_ovf;
  assign a_neg       = div_signed & op_a[XLEN-1];
  assign b_neg       = div_signed & op_b[XLEN-1];
  assign a_abs       = a_neg ? '0 - op_a : op_a;
  assign b_abs       = b_neg ? '0 - op_b : op_b;

  always_comb begin
    fast_res = '0;
    if (div_by_zero)  fast_res = is_rem ? op_a : '1;
    else if (div_ovf) fast_res = is_rem ? '0 : op_a;
  end

  always_comb begin
    alu_res = '0;
    case (ID_AluOp)
      5'd0:  alu_res = op_a + op_b;
      5'd1:  alu_res = op_a - op_b;
      5'd2:  alu_res = op_a << op_b[4:0];
      5'd3:  alu_res = {{XLEN-1{1'b0}}, $signed(op_a) < $signed(op_b)};
      5'd4:  alu_res = {{XLEN-1{1'b0}}, op_a < op_b};
      5'd5:  alu_res = op_a ^ op_b;
      5'd6:  alu_res = op_a >> op_b[4:0];
      5'd7:  alu_res = $signed(op_a) >>> op_b[4:0];
      5'd8:  alu_res = op_a | op_b;
      5'd9:  alu_res = op_a & op_b;
      5'd10: alu_res = op_b;
      5'd11: alu_res = mul_p[XLEN-1:0];
      5'd12, 5'd13, 5'd14: alu_res = mul_p[2*XLEN-1:XLEN];
      5'd16, 5'd17, 5'd18, 5'd19: alu_res = fast_res;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (ID_BrFunct3)
      3'd0: br_taken = ID_Rs1data == ID_Rs2data;
      3'd1: br_taken = ID_Rs1data != ID_Rs2data;
      3'd4: br_taken = $signed(ID_Rs1data) < $signed(ID_Rs2data);
      3'd5: br_taken = $signed(ID_Rs1data) >= $signed(ID_Rs2data);
      3'd6: br_taken = ID_Rs1data < ID_Rs2data;
      3'd7: br_taken = ID_Rs1data >= ID_Rs2data;
      default: br_taken = 1'b0;
    endcase
  end

  // Restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  assign step_tmp  = {rem_q, quo_q[XLEN-1]};
  assign step_diff = step_tmp - {1'b0, dvsr_q};
  assign q_fix     = negq_q ? '0 - quo_q : quo_q;
  assign r_fix     = negr_q ? '0 - rem_q : rem_q;
  assign div_res   = is_rem ? r_fix : q_fix;

  assign EX_Stall = (state_q == StIdle && div_start) || state_q == StBusy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    unique case (state_q)
      StIdle: begin
        if (div_start) begin
          quo_d   = a_abs;
          rem_d   = '0;
          dvsr_d  = b_abs;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!step_diff[XLEN]) begin
          rem_d = step_diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = step_tmp[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign load = ID_Valid && !EX_Stall;

  always_comb begin
    redirect_d = 1'b0;
    target_d   = '0;
    pc4_d      = '0;
    res_d      = '0;
    wdata_d    = '0;
    imm_d      = '0;
    regd_d     = '0;
    wreg_d     = 1'b0;
    wmem_d     = 1'b0;
    rmem_d     = 1'b0;
    wbsel_d    = '0;
    if (load) begin
      redirect_d = (ID_Branch && br_taken) || ID_Jump == 2'd1 || ID_Jump == 2'd2;
      target_d   = (ID_Jump == 2'd2) ? ((ID_Rs1data + ID_Imm) & ~{{XLEN-1{1'b0}}, 1'b1})
                                     : ID_Pc + ID_Imm;
      pc4_d      = ID_Pc4;
      res_d      = (state_q == StDone) ? div_res : alu_res;
      wdata_d    = ID_Rs2data;
      imm_d      = ID_Imm;
      regd_d     = ID_RegD;
      wreg_d     = ID_WReg;
      wmem_d     = ID_Wmem;
      rmem_d     = ID_Rmem;
      wbsel_d    = ID_WBsel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      pc4_q      <= '0;
      res_q      <= '0;
      wdata_q    <= '0;
      imm_q      <= '0;
      regd_q     <= '0;
      wreg_q     <= 1'b0;
      wmem_q     <= 1'b0;
      rmem_q     <= 1'b0;
      wbsel_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      negq_q     <= negq_d;
      negr_q     <= negr_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      pc4_q      <= pc4_d;
      res_q      <= res_d;
      wdata_q    <= wdata_d;
      imm_q      <= imm_d;
      regd_q     <= regd_d;
      wreg_q     <= wreg_d;
      wmem_q     <= wmem_d;
      rmem_q     <= rmem_d;
      wbsel_q    <= wbsel_d;
    end
  end

  assign EX_Redirect   = redirect_q;
  assign EX_Target     = target_q;
  assign EX_Pc4        = pc4_q;
  assign EX_Alu_Result = res_q;
  assign EX_Wdata      = wdata_q;
  assign EX_Imm        = imm_q;
  assign EX_RegD       = regd_q;
  assign EX_WReg       = wreg_q;
  assign EX_Wmem       = wmem_q;
  assign EX_Rmem       = rmem_q;
  assign EX_WBsel      = wbsel_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: random ALU/branch stimulus against an arithmetic reference
// model, plus directed divide latency, fast-path, back-to-back and reset scenarios.
module tb_ex_stage;

  logic        clk, rst_n;
  logic        ID_Valid, ID_ASel, ID_BSel, ID_Branch, ID_WReg, ID_Wmem, ID_Rmem;
  logic [31:0] ID_Pc, ID_Pc4, ID_Rs1data, ID_Rs2data, ID_Imm;
  logic [4:0]  ID_RegD, ID_AluOp;
  logic [2:0]  ID_BrFunct3;
  logic [1:0]  ID_Jump, ID_WBsel;
  logic        EX_Stall, EX_Redirect, EX_WReg, EX_Wmem, EX_Rmem;
  logic [31:0] EX_Target, EX_Pc4, EX_Alu_Result, EX_Wdata, EX_Imm;
  logic [4:0]  EX_RegD;
  logic [1:0]  EX_WBsel;

  int errors = 0;
  int checks = 0;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .ID_Valid(ID_Valid), .ID_Pc(ID_Pc), .ID_Pc4(ID_Pc4),
    .ID_Rs1data(ID_Rs1data), .ID_Rs2data(ID_Rs2data), .ID_Imm(ID_Imm), .ID_RegD(ID_RegD),
    .ID_AluOp(ID_AluOp), .ID_ASel(ID_ASel), .ID_BSel(ID_BSel), .ID_Branch(ID_Branch),
    .ID_BrFunct3(ID_BrFunct3), .ID_Jump(ID_Jump), .ID_WReg(ID_WReg), .ID_Wmem(ID_Wmem),
    .ID_Rmem(ID_Rmem), .ID_WBsel(ID_WBsel), .EX_Stall(EX_Stall), .EX_Redirect(EX_Redirect),
    .EX_Target(EX_Target), .EX_Pc4(EX_Pc4), .EX_Alu_Result(EX_Alu_Result),
    .EX_Wdata(EX_Wdata), .EX_Imm(EX_Imm), .EX_RegD(EX_RegD), .EX_WReg(EX_WReg),
    .EX_Wmem(EX_Wmem), .EX_Rmem(EX_Rmem), .EX_WBsel(EX_WBsel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RV32IM semantics computed with plain integer arithmetic.
  function automatic logic [31:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa, sb, sr;
    longint la, lb, p;
    logic [63:0] pu;
    sa = a;
    sb = b;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  begin sr = sa >>> b[4:0]; return sr; end
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
      5'd11: return a * b;
      5'd12: begin la = sa; lb = sb; p = la * lb; return p[63:32]; end
      5'd13: begin la = sa; lb = {32'd0, b}; p = la * lb; return p[63:32]; end
      5'd14: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      5'd16: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sr = sa / sb; return sr;
      end
      5'd17: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd18: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sr = sa % sb; return sr;
      end
      5'd19: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_idle();
    ID_Valid = 0; ID_Pc = 0; ID_Pc4 = 0; ID_Rs1data = 0; ID_Rs2data = 0; ID_Imm = 0;
    ID_RegD = 0; ID_AluOp = 0; ID_ASel = 0; ID_BSel = 0; ID_Branch = 0; ID_BrFunct3 = 0;
    ID_Jump = 0; ID_WReg = 0; ID_Wmem = 0; ID_Rmem = 0; ID_WBsel = 0;
  endtask

  task automatic set_rr(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    set_idle();
    ID_Valid = 1; ID_AluOp = op; ID_Rs1data = a; ID_Rs2data = b; ID_WReg = 1;
    ID_RegD = 5'($urandom); ID_Pc = $urandom; ID_Pc4 = ID_Pc + 4; ID_Imm = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 0;
    set_rr(5'd0, 32'd5, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({EX_Alu_Result, EX_WReg, EX_Redirect, EX_Target, EX_Pc4, EX_Stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h wreg=%b redir=%b tgt=%h pc4=%h stall=%b, want 0",
               EX_Alu_Result, EX_WReg, EX_Redirect, EX_Target, EX_Pc4, EX_Stall);
    end
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (EX_Alu_Result !== 32'd12 || EX_WReg !== 1'b1) begin
      errors++;
      $display("FAIL first_add: got res=%h wreg=%b, want 0000000c 1", EX_Alu_Result, EX_WReg);
    end
    rst_n = 0;
    #1;
    checks++;
    if (EX_Alu_Result !== 0 || EX_WReg !== 0 || EX_Pc4 !== 0) begin
      errors++;
      $display("FAIL async_reset: got res=%h wreg=%b pc4=%h, want 0", EX_Alu_Result, EX_WReg,
               EX_Pc4);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_alu_random();
    logic [4:0]  op;
    logic [31:0] a, b, exp;
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom);
      if (op inside {[5'd16:5'd19]}) op = op - 5'd16;
      set_rr(op, $urandom, $urandom);
      if (i % 4 == 1) ID_Rs2data = 32'($urandom_range(0, 40));
      ID_ASel = 1'($urandom); ID_BSel = 1'($urandom);
      ID_Wmem = 1'($urandom); ID_Rmem = 1'($urandom); ID_WBsel = 2'($urandom);
      a = ID_ASel ? ID_Pc : ID_Rs1data;
      b = ID_BSel ? ID_Imm : ID_Rs2data;
      exp = model_alu(op, a, b);
      @(posedge clk); #1;
      checks++;
      if (EX_Alu_Result !== exp) begin
        errors++;
        $display("FAIL alu op=%0d a=%h b=%h: got %h want %h", op, a, b, EX_Alu_Result, exp);
      end
      checks++;
      if (EX_WReg !== 1'b1 || EX_RegD !== ID_RegD || EX_Wdata !== ID_Rs2data ||
          EX_Imm !== ID_Imm || EX_Pc4 !== ID_Pc4 || EX_Wmem !== ID_Wmem ||
          EX_Rmem !== ID_Rmem || EX_WBsel !== ID_WBsel || EX_Redirect !== 1'b0 ||
          EX_Stall !== 1'b0) begin
        errors++;
        $display("FAIL passthru op=%0d: got regd=%0d wdata=%h imm=%h pc4=%h redir=%b stall=%b",
                 op, EX_RegD, EX_Wdata, EX_Imm, EX_Pc4, EX_Redirect, EX_Stall);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3_tab [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic exp_t;
    logic [31:0] exp_tgt;
    for (int i = 0; i < 26; i++) begin
      set_rr(5'd1, $urandom, $urandom);
      ID_WReg = 0; ID_Branch = 1; ID_BrFunct3 = f3_tab[i % 6];
      if (i < 2) begin
        ID_Rs1data = 32'hFFFF_FFFF; ID_Rs2data = 1; ID_Pc = 32'h100; ID_Imm = 32'h20;
        ID_BrFunct3 = (i == 0) ? 3'd4 : 3'd6;
      end else if ($urandom_range(0, 2) == 0) begin
        ID_Rs2data = ID_Rs1data;
      end
      exp_t = model_taken(ID_BrFunct3, ID_Rs1data, ID_Rs2data);
      exp_tgt = ID_Pc + ID_Imm;
      @(posedge clk); #1;
      checks++;
      if (EX_Redirect !== exp_t || (exp_t && EX_Target !== exp_tgt)) begin
        errors++;
        $display("FAIL branch f3=%0d: got redir=%b tgt=%h, want redir=%b tgt=%h",
                 ID_BrFunct3, EX_Redirect, EX_Target, exp_t, exp_tgt);
      end
    end
  endtask

  task automatic test_jumps();
    set_rr(5'd10, 32'h1003, 32'd0);
    ID_Jump = 2; ID_Imm = 4; ID_BSel = 1;
    @(posedge clk); #1;
    checks++;
    if (EX_Target !== 32'h1006 || EX_Redirect !== 1'b1 || EX_Pc4 !== ID_Pc4) begin
      errors++;
      $display("FAIL jalr: got tgt=%h redir=%b pc4=%h, want 00001006 1 %h", EX_Target,
               EX_Redirect, EX_Pc4, ID_Pc4);
    end
    set_rr(5'd10, $urandom, $urandom);
    ID_Jump = 1;
    @(posedge clk); #1;
    checks++;
    if (EX_Target !== ID_Pc + ID_Imm || EX_Redirect !== 1'b1) begin
      errors++;
      $display("FAIL jal: got tgt=%h redir=%b, want %h 1", EX_Target, EX_Redirect,
               ID_Pc + ID_Imm);
    end
    ID_Valid = 0;
    @(posedge clk); #1;
    checks++;
    if (EX_Redirect !== 0 || EX_WReg !== 0 || EX_Target !== 0 || EX_Alu_Result !== 0) begin
      errors++;
      $display("FAIL bubble: got redir=%b wreg=%b tgt=%h res=%h, want 0", EX_Redirect, EX_WReg,
               EX_Target, EX_Alu_Result);
    end
  endtask

  // Presents one iterative divide and follows it through stall, bubbles and result.
  task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int stalls, bad_bubbles;
    logic [31:0] exp;
    logic [4:0] rd;
    set_rr(op, a, b);
    rd = ID_RegD;
    exp = model_alu(op, a, b);
    stalls = 0;
    bad_bubbles = 0;
    #1;
    while (EX_Stall === 1'b1 && stalls < 40) begin
      stalls++;
      @(posedge clk); #1;
      if (EX_WReg !== 1'b0) bad_bubbles++;
    end
    checks++;
    if (stalls != 33 || bad_bubbles != 0) begin
      errors++;
      $display("FAIL div_stall op=%0d: got stall cycles=%0d non-bubbles=%0d, want 33 0", op,
               stalls, bad_bubbles);
    end
    @(posedge clk); #1;
    checks++;
    if (EX_Alu_Result !== exp || EX_WReg !== 1'b1 || EX_RegD !== rd) begin
      errors++;
      $display("FAIL div_result op=%0d a=%h b=%h: got %h wreg=%b rd=%0d, want %h 1 %0d", op, a,
               b, EX_Alu_Result, EX_WReg, EX_RegD, exp, rd);
    end
  endtask

  task automatic test_div_iter();
    logic [4:0] op;
    logic [31:0] a, b;
    run_div(5'd16, -32'sd100, 32'd7);
    run_div(5'd18, -32'sd100, 32'd7);
    for (int i = 0; i < 4; i++) begin
      op = 5'd16 + 5'(i);
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (b == 0) b = 3;
      run_div(op, a, b);
    end
  endtask

  task automatic test_div_fast();
    logic [4:0]  op_tab [4] = '{5'd17, 5'd18, 5'd16, 5'd19};
    logic [31:0] a_tab  [4] = '{32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [31:0] b_tab  [4] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] exp;
    logic stall0;
    for (int i = 0; i < 4; i++) begin
      set_rr(op_tab[i], a_tab[i], b_tab[i]);
      exp = model_alu(op_tab[i], a_tab[i], b_tab[i]);
      #1;
      stall0 = EX_Stall;
      @(posedge clk); #1;
      checks++;
      if (stall0 !== 1'b0 || EX_Alu_Result !== exp || EX_WReg !== 1'b1) begin
        errors++;
        $display("FAIL div_fast op=%0d: got stall=%b res=%h wreg=%b, want 0 %h 1", op_tab[i],
                 stall0, EX_Alu_Result, EX_WReg, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_div(5'd17, 32'hFFFF_FFF0, 32'd9);
    run_div(5'd19, 32'hFFFF_FFF0, 32'd9);
    set_rr(5'd0, 32'd1, 32'd2);
    @(posedge clk); #1;
    checks++;
    if (EX_Alu_Result !== 32'd3 || EX_WReg !== 1'b1) begin
      errors++;
      $display("FAIL after_b2b_add: got %h wreg=%b, want 00000003 1", EX_Alu_Result, EX_WReg);
    end
  endtask

  task automatic test_reset_mid_div();
    int bad;
    set_rr(5'd16, 32'd1000, 32'd3);
    repeat (11) @(posedge clk);
    #2;
    rst_n = 0;
    ID_Valid = 0;
    #1;
    checks++;
    if (EX_Alu_Result !== 0 || EX_WReg !== 0 || EX_Stall !== 0 || EX_Target !== 0) begin
      errors++;
      $display("FAIL mid_div_reset: got res=%h wreg=%b stall=%b tgt=%h, want 0", EX_Alu_Result,
               EX_WReg, EX_Stall, EX_Target);
    end
    @(posedge clk); #1;
    rst_n = 1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (EX_WReg !== 0 || EX_Stall !== 0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL aborted_div_emitted: got %0d cycles with wreg/stall set, want 0", bad);
    end
    set_rr(5'd0, 32'd5, 32'd7);
    @(posedge clk); #1;
    checks++;
    if (EX_Alu_Result !== 32'd12 || EX_WReg !== 1'b1 || EX_Stall !== 1'b0) begin
      errors++;
      $display("FAIL add_after_reset: got %h wreg=%b stall=%b, want 0000000c 1 0",
               EX_Alu_Result, EX_WReg, EX_Stall);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_alu_random();
    test_branch();
    test_jumps();
    test_div_iter();
    test_div_fast();
    test_back_to_back();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipelined RV32IM core, between the ID/EX boundary and the memory stage. It performs ALU and single-cycle multiply operations and resolves branches and jumps. It runs signed and unsigned divide/remainder on an iterative 32-cycle radix-2 unit that stalls upstream. It registers everything the memory stage consumes into the EX_* pipeline register.

## Interface

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports (reset is asynchronous and active-low; one clock):
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ID_Valid  in  1  ID/EX slot holds a real instruction; 0 = bubble
- ID_Pc  in  32  instruction PC
- ID_Pc4  in  32  PC+4
- ID_Rs1data  in  32  forwarded rs1 value
- ID_Rs2data  in  32  forwarded rs2 value
- ID_Imm  in  32  sign-extended immediate
- ID_RegD  in  5  destination register
- ID_AluOp  in  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB, 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 16 DIV, 17 DIVU, 18 REM, 19 REMU; other codes give 0
- ID_ASel  in  1  operand A: 0 = rs1, 1 = PC
- ID_BSel  in  1  operand B: 0 = rs2, 1 = imm
- ID_Branch  in  1  conditional branch; ID_BrFunct3 selects the compare
- ID_BrFunct3  in  3  BEQ 0, BNE 1, BLT 4, BGE 5, BLTU 6, BGEU 7
- ID_Jump  in  2  0 none, 1 JAL, 2 JALR
- ID_WReg, ID_Wmem, ID_Rmem  in  1 each  control for later stages
- ID_WBsel  in  2  write-back select, passed through
- EX_Stall  out  1  hold IF/ID/ID-EX; divide in progress
- EX_Redirect  out  1  registered: taken branch or jump
- EX_Target  out  32  registered redirect target
- EX_Pc4, EX_Alu_Result, EX_Wdata, EX_Imm  out  32 each  to memory stage
- EX_RegD  out  5  to memory stage
- EX_WReg, EX_Wmem, EX_Rmem  out  1 each  to memory stage
- EX_WBsel  out  2  to memory stage

## Operation

Operands:
- A = ID_ASel ? ID_Pc : ID_Rs1data.
- B = ID_BSel ? ID_Imm : ID_Rs2data.
- Shifts use B[4:0].
- MUL* are combinational 64-bit products: low word for MUL, high word for the others, with RV32M signedness.

Branch and jump resolution:
- Branch compare uses rs1 vs rs2; branch target = ID_Pc+ID_Imm.
- JAL target = ID_Pc+ID_Imm.
- JALR target = (ID_Rs1data+ID_Imm) & ~1.
- EX_Redirect/EX_Target load on the same edge as the EX_* register.

Bubble rule:
- When ID_Valid=0, or while EX_Stall=1, the edge loads a bubble.
- Bubble: EX_WReg=EX_Wmem=EX_Rmem=0, EX_Redirect=0.
- Data fields of a bubble are don't-care; the bench requires 0.

EX_Wdata = ID_Rs2data.

Divide FSM (states IDLE, BUSY, DONE):
- IDLE: a valid DIV/DIVU/REM/REMU with divisor≠0 and not signed overflow:
  - EX_Stall=1 (combinational).
  - Latch |dividend|, |divisor|, and the result sign flags.
  - cnt=0; go to BUSY.
- Fast path, no stall, single cycle:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = dividend.
  - DIV/REM of 0x80000000 by −1: quotient 0x80000000, remainder 0.
- BUSY: one restoring shift-subtract per cycle; cnt increments; EX_Stall=1. When cnt=31 completes, go to DONE.
- DONE:
  - EX_Stall=0.
  - Apply the sign fixup: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - Load the result into EX_Alu_Result with the instruction's controls; go to IDLE.
- While not IDLE, ID_* is held by upstream and is not re-sampled for a new divide.

## Timing

Reset (rst_n=0, asynchronous):
- All EX_* outputs, EX_Redirect and EX_Target = 0.
- FSM = IDLE; cnt = 0.
- EX_Stall = 0 once in IDLE.
- Reset mid-divide aborts it; no result is emitted.

Latency:
- Non-divide instructions: 1 cycle, ID inputs to EX_* on the next edge.
- Iterative divide: presented in cycle 0; EX_Stall high in cycles 0..32; result visible after the edge ending cycle 33. Total occupancy 34 cycles; 33 bubbles emitted.
- Back-to-back divides: the second starts in the cycle after DONE, with no extra gap.
- EX_Stall is combinational from state and ID_*, with no register in the path.

## Test plan

- Reset release, then ADD rs1=5 rs2=7 -> EX_Alu_Result=12, EX_WReg=1 one edge later; all outputs 0 during reset.
- BLT rs1=0xFFFFFFFF rs2=1, Pc=0x100, Imm=0x20 -> EX_Redirect=1, EX_Target=0x120. The same operands with BLTU -> EX_Redirect=0.
- JALR rs1=0x1003 Imm=4 -> EX_Target=0x1006, EX_Redirect=1, EX_Pc4 = ID_Pc4.
- DIV −100/7 -> EX_Stall high for exactly 33 cycles, 33 bubbles (EX_WReg=0), then EX_Alu_Result=0xFFFFFFF2 (−14). REM with the same operands -> 0xFFFFFFFE (−2).
- DIVU x/0 -> 0xFFFFFFFF and REM 0x80000000/−1 -> 0, each in 1 cycle with no stall.
- rst_n pulsed low at BUSY cycle 10 -> outputs 0 immediately, FSM IDLE, EX_Stall=0 after release; a following ADD completes normally.
